// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM power-up initialisation sequencer.
//   init_state_t : sequencer states (values are stable so a debug readout can be decoded)
//   CMD_*        : {CS_N, RAS_N, CAS_N, WE_N} command encodings
//   mode_word()  : builds the 13-bit LOAD MODE address word
//   timer_width(): width of the shared wait counter for a set of gap lengths
package sdram_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PWR_WAIT = 4'd1,
        ST_PRE      = 4'd2,
        ST_PRE_WAIT = 4'd3,
        ST_REF      = 4'd4,
        ST_REF_WAIT = 4'd5,
        ST_LOAD     = 4'd6,
        ST_MRD_WAIT = 4'd7,
        ST_DONE     = 4'd8
    } init_state_t;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_PALL = 4'b0010;

    // bt is the literal A3 bit (0 = sequential, 1 = interleaved).
    function automatic logic [12:0] mode_word(input logic       wb,
                                              input logic [2:0] cl,
                                              input logic       bt,
                                              input logic [2:0] bl);
        return {3'b000, wb, 2'b00, cl, bt, bl};
    endfunction

    // The counter is loaded with (gap - 1) at most, so $clog2 of the largest
    // gap is enough; never let the width collapse to zero.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sdram_wait_timer.sv
// Loadable down-counter used for every timing gap of the init sequencer.
//   iclk, ireset : clock, asynchronous active-high reset
//   load         : load load_val this cycle (takes priority over counting)
//   load_val     : value to load
//   value        : current count
//   zero         : count has reached zero; the counter then holds at zero
module sdram_wait_timer #(
    parameter int W = 4
) (
    input  logic         iclk,
    input  logic         ireset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign value = cnt;
    assign zero  = (cnt == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer for the 16-bit SDR SDRAM port.
// Sequence: power-up wait -> PRECHARGE ALL -> N_REF x AUTO REFRESH -> LOAD MODE -> done.
//   iclk, ireset : clock, asynchronous active-high reset
//   ireq         : start request, acted on only in IDLE
//   iredo        : re-init request, acted on only in DONE (skips the power-up wait)
//   ienb         : bus ownership; when low every DRAM_* pin is high-Z (FSM keeps running)
//   ofin         : level, high while initialisation is complete
//   obusy        : high in every state except IDLE and DONE
//   DRAM_*       : SDRAM pins; command/address are registered, one cycle per command
//   dbg_state    : current FSM state (init_state_t encoding)
//   dbg_wait     : current wait-counter value
// Request protocol: ireq/iredo are single-cycle-sampled levels with no ready/ack.
// A request is consumed on the rising edge where the FSM is in the matching state
// (ireq in IDLE, iredo in DONE); at any other edge it is dropped, never queued.
// If both are high in IDLE, ireq is the one that is acted on.
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int  T_PWR_CYC = 20000,
    parameter int  T_RP      = 2,
    parameter int  T_RFC     = 7,
    parameter int  T_MRD     = 2,
    parameter int  N_REF     = 8,
    parameter int  CAS_LAT   = 2,
    parameter int  BURST_LEN = 3,
    parameter int  BURST_SEQ = 1,
    parameter int  WB_SINGLE = 1,
    localparam int WAIT_W    = timer_width(T_PWR_CYC, T_RP, T_RFC, T_MRD)
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              ireq,
    input  logic              iredo,
    input  logic              ienb,
    output logic              ofin,
    output logic              obusy,
    output logic              DRAM_CLK,
    output logic              DRAM_CKE,
    output logic [12:0]       DRAM_ADDR,
    output logic [1:0]        DRAM_BA,
    output logic              DRAM_CS_N,
    output logic              DRAM_RAS_N,
    output logic              DRAM_CAS_N,
    output logic              DRAM_WE_N,
    output logic              DRAM_LDQM,
    output logic              DRAM_UDQM,
    output logic [15:0]       DRAM_DQ,
    output logic [3:0]        dbg_state,
    output logic [WAIT_W-1:0] dbg_wait
);

    localparam int REF_W = $clog2(N_REF + 1);

    // Wait states last (gap - 1) cycles after their one-cycle command state,
    // except the power-up wait which has no command state in front of it.
    localparam logic [WAIT_W-1:0] LD_PWR = WAIT_W'(T_PWR_CYC - 1);
    localparam logic [WAIT_W-1:0] LD_RP  = WAIT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
    localparam logic [WAIT_W-1:0] LD_RFC = WAIT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
    localparam logic [WAIT_W-1:0] LD_MRD = WAIT_W'((T_MRD > 1) ? T_MRD - 2 : 0);

    localparam logic [REF_W-1:0] REF_LAST   = REF_W'(N_REF);
    localparam logic [REF_W:0]   REF_TARGET = (REF_W + 1)'(N_REF);

    localparam logic [12:0] MODE = mode_word(1'(WB_SINGLE), 3'(CAS_LAT),
                                             1'(BURST_SEQ == 0), 3'(BURST_LEN));

    init_state_t       state, state_d;
    logic              tmr_load, tmr_zero;
    logic [WAIT_W-1:0] tmr_val, tmr_value;
    logic [REF_W-1:0]  ref_cnt;
    logic [REF_W:0]    ref_issued;
    logic              more_refs;
    logic [3:0]        cmd_d, cmd_q;
    logic [12:0]       addr_d, addr_q;
    logic [1:0]        ba_d, ba_q;
    logic              fin_q;

    sdram_wait_timer #(.W(WAIT_W)) u_timer (
        .iclk     (iclk),
        .ireset   (ireset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // While in REF the current refresh is not yet counted; include it so the
    // T_RFC == 1 path (REF -> REF directly) decides on the right total.
    assign ref_issued = (state == ST_REF) ? ({1'b0, ref_cnt} + (REF_W + 1)'(1))
                                          : {1'b0, ref_cnt};
    assign more_refs  = (ref_issued < REF_TARGET);

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state   <= ST_IDLE;
            ref_cnt <= '0;
        end else begin
            state <= state_d;
            if (state == ST_PRE) begin
                ref_cnt <= '0;
            end else if (state == ST_REF && ref_cnt != REF_LAST) begin
                ref_cnt <= ref_cnt + REF_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (ireq) begin
                    state_d  = ST_PWR_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_PWR;
                end
            end
            ST_PWR_WAIT: if (tmr_zero) state_d = ST_PRE;
            ST_PRE: begin
                if (T_RP > 1) begin
                    state_d  = ST_PRE_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RP;
                end else begin
                    state_d = ST_REF;
                end
            end
            ST_PRE_WAIT: if (tmr_zero) state_d = ST_REF;
            ST_REF: begin
                if (T_RFC > 1) begin
                    state_d  = ST_REF_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RFC;
                end else begin
                    state_d = more_refs ? ST_REF : ST_LOAD;
                end
            end
            ST_REF_WAIT: if (tmr_zero) state_d = more_refs ? ST_REF : ST_LOAD;
            ST_LOAD: begin
                if (T_MRD > 1) begin
                    state_d  = ST_MRD_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_MRD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_MRD_WAIT: if (tmr_zero) state_d = ST_DONE;
            ST_DONE: if (iredo) state_d = ST_PRE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin command decoded from the current state and registered, so each
    // command appears on the pins for exactly the cycle after its state.
    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        ba_d   = '0;
        case (state)
            ST_PRE: begin
                cmd_d  = CMD_PALL;
                addr_d = 13'h0400;
                ba_d   = 2'b11;
            end
            ST_REF:  cmd_d = CMD_REF;
            ST_LOAD: begin
                cmd_d  = CMD_MRS;
                addr_d = MODE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            cmd_q  <= CMD_NOP;
            addr_q <= '0;
            ba_q   <= '0;
            fin_q  <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            addr_q <= addr_d;
            ba_q   <= ba_d;
            fin_q  <= (state == ST_DONE);
        end
    end

    assign ofin      = fin_q;
    assign obusy     = (state != ST_IDLE) && (state != ST_DONE);
    assign dbg_state = state;
    assign dbg_wait  = tmr_value;

    assign DRAM_CLK  = ienb ? ~iclk   : 1'bz;
    assign DRAM_CKE  = ienb ? 1'b1    : 1'bz;
    assign DRAM_ADDR = ienb ? addr_q  : 13'bz;
    assign DRAM_BA   = ienb ? ba_q    : 2'bz;
    assign DRAM_CS_N  = ienb ? cmd_q[3] : 1'bz;
    assign DRAM_RAS_N = ienb ? cmd_q[2] : 1'bz;
    assign DRAM_CAS_N = ienb ? cmd_q[1] : 1'bz;
    assign DRAM_WE_N  = ienb ? cmd_q[0] : 1'bz;
    assign DRAM_LDQM = ienb ? 1'b1    : 1'bz;
    assign DRAM_UDQM = ienb ? 1'b1    : 1'bz;
    assign DRAM_DQ   = ienb ? 16'h0000 : 16'bz;

endmodule
